// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Stall/bubble generator that sits beside the IF/ID register. It covers the
// RAW hazards that operand forwarding cannot bypass:
//   - a load followed by a dependent instruction;
//   - a branch compared in ID that depends on an ALU result still in EX;
//   - a branch compared in ID that depends on a load in EX or in MEM.
// While stalling, the unit holds the PC and IF/ID and injects a bubble into ID/EX.
// A taken branch flushes IF/ID, but only when no stall is active.
// A load feeding a branch from EX needs two stall cycles; the HOLD state supplies the second one.
// StallCount is a saturating count of stall cycles, kept for performance debug.
module hazard_stall_unit #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [4:0]       IFIDrs,
   input  logic [4:0]       IFIDrt,
   input  logic             IFIDUsesRt,
   input  logic             IFIDBranch,
   input  logic [4:0]       IDEXWriteReg,
   input  logic             IDEXRegWrite,
   input  logic             IDEXMemRead,
   input  logic [4:0]       EXMemWriteReg,
   input  logic             EXMemMemRead,
   input  logic             BranchTaken,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IDEXBubble,
   output logic             IFIDFlush,
   output logic [CNT_W-1:0] StallCount
);

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_r;
   state_t           state_nxt_s;
   logic             stall_s;
   logic [CNT_W-1:0] cnt_r;

   logic             ex_match_s;
   logic             mem_match_s;
   logic             h_lu_s;
   logic             h_ba_s;
   logic             h_bl2_s;
   logic             h_bl1_s;

   // True when a non-zero write register feeds one of the ID instruction's sources.
   function automatic logic src_match(
      input logic [4:0] wr,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       uses_rt
   );
      return (wr != 5'd0) && ((wr == rs) || (uses_rt && (wr == rt)));
   endfunction

   assign ex_match_s  = src_match(IDEXWriteReg,  IFIDrs, IFIDrt, IFIDUsesRt);
   assign mem_match_s = src_match(EXMemWriteReg, IFIDrs, IFIDrt, IFIDUsesRt);

   assign h_lu_s  = IDEXMemRead && ex_match_s;
   assign h_ba_s  = IFIDBranch && IDEXRegWrite && !IDEXMemRead && ex_match_s;
   assign h_bl2_s = IFIDBranch && IDEXMemRead && ex_match_s;
   assign h_bl1_s = IFIDBranch && EXMemMemRead && mem_match_s;

   // State register; reset aborts any pending HOLD cycle.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r <= RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state and Mealy stall decision; a branch on a load in EX wins and takes the 2-cycle path.
   always_comb begin
      state_nxt_s = RUN;
      stall_s     = 1'b0;
      case (state_r)
         RUN: begin
            stall_s = h_lu_s | h_ba_s | h_bl1_s | h_bl2_s;
            if (h_bl2_s) begin
               state_nxt_s = HOLD;
            end else begin
               state_nxt_s = RUN;
            end
         end
         HOLD: begin
            stall_s     = 1'b1;
            state_nxt_s = RUN;
         end
         default: begin
            stall_s     = 1'b0;
            state_nxt_s = RUN;
         end
      endcase
   end

   // Pipeline control outputs; reset forces the free-running values regardless of inputs.
   always_comb begin
      PCWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IDEXBubble = 1'b0;
      IFIDFlush  = 1'b0;
      if (Reset) begin
         PCWrite    = 1'b1;
         IFIDWrite  = 1'b1;
         IDEXBubble = 1'b0;
         IFIDFlush  = 1'b0;
      end else begin
         PCWrite    = !stall_s;
         IFIDWrite  = !stall_s;
         IDEXBubble = stall_s;
         IFIDFlush  = BranchTaken && !stall_s;
      end
   end

   // Saturating stall-cycle counter.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (stall_s && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign StallCount = cnt_r;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit (CNT_W=4 build so saturation is reachable).
// Reference model: pending extra stall cycles tracked as an integer and
// hazards computed directly from the rules; counter is min(sum, 2^CNT_W-1).
module tb_hazard_stall_unit;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             Clk;
   logic             Reset;
   logic [4:0]       IFIDrs;
   logic [4:0]       IFIDrt;
   logic             IFIDUsesRt;
   logic             IFIDBranch;
   logic [4:0]       IDEXWriteReg;
   logic             IDEXRegWrite;
   logic             IDEXMemRead;
   logic [4:0]       EXMemWriteReg;
   logic             EXMemMemRead;
   logic             BranchTaken;
   logic             PCWrite;
   logic             IFIDWrite;
   logic             IDEXBubble;
   logic             IFIDFlush;
   logic [CNT_W-1:0] StallCount;

   int total = 0;
   int bad   = 0;
   int hold_left = 0;
   int mcnt = 0;

   hazard_stall_unit #(.CNT_W(CNT_W)) dut (
      .Clk(Clk), .Reset(Reset),
      .IFIDrs(IFIDrs), .IFIDrt(IFIDrt), .IFIDUsesRt(IFIDUsesRt), .IFIDBranch(IFIDBranch),
      .IDEXWriteReg(IDEXWriteReg), .IDEXRegWrite(IDEXRegWrite), .IDEXMemRead(IDEXMemRead),
      .EXMemWriteReg(EXMemWriteReg), .EXMemMemRead(EXMemMemRead), .BranchTaken(BranchTaken),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
      .IFIDFlush(IFIDFlush), .StallCount(StallCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit reads(input logic [4:0] x);
      return (x != 5'd0) && ((x == IFIDrs) || (IFIDUsesRt && (x == IFIDrt)));
   endfunction

   task automatic clear_inputs();
      IFIDrs = 5'd0; IFIDrt = 5'd0; IFIDUsesRt = 1'b0; IFIDBranch = 1'b0;
      IDEXWriteReg = 5'd0; IDEXRegWrite = 1'b0; IDEXMemRead = 1'b0;
      EXMemWriteReg = 5'd0; EXMemMemRead = 1'b0; BranchTaken = 1'b0;
   endtask

   // One clock cycle: inputs already applied just after the previous edge.
   task automatic step(input string tag);
      bit lu, ba, bl2, bl1, st;
      lu  = IDEXMemRead && reads(IDEXWriteReg);
      ba  = IFIDBranch && IDEXRegWrite && !IDEXMemRead && reads(IDEXWriteReg);
      bl2 = IFIDBranch && IDEXMemRead && reads(IDEXWriteReg);
      bl1 = IFIDBranch && EXMemMemRead && reads(EXMemWriteReg);
      st  = (hold_left > 0) || lu || ba || bl1 || bl2;
      #2;
      chk({tag, ".pcw"},   {31'd0, PCWrite},    {31'd0, !st});
      chk({tag, ".ifw"},   {31'd0, IFIDWrite},  {31'd0, !st});
      chk({tag, ".bub"},   {31'd0, IDEXBubble}, {31'd0, st});
      chk({tag, ".flush"}, {31'd0, IFIDFlush},  {31'd0, BranchTaken && !st});
      @(posedge Clk);
      if (hold_left > 0) hold_left = 0;
      else if (bl2) hold_left = 1;
      if (st && mcnt < CMAX) mcnt++;
      #1;
      chk({tag, ".cnt"}, {28'd0, StallCount}, mcnt);
   endtask

   // Pulse reset starting just after an edge; checks forced outputs asynchronously.
   task automatic do_reset(input string tag);
      Reset = 1'b1;
      #1;
      hold_left = 0;
      mcnt = 0;
      chk({tag, ".pcw"},   {31'd0, PCWrite},    32'd1);
      chk({tag, ".ifw"},   {31'd0, IFIDWrite},  32'd1);
      chk({tag, ".bub"},   {31'd0, IDEXBubble}, 32'd0);
      chk({tag, ".flush"}, {31'd0, IFIDFlush},  32'd0);
      chk({tag, ".cnt"},   {28'd0, StallCount}, 32'd0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1;
      clear_inputs();
      BranchTaken = 1'b1;
      IDEXMemRead = 1'b1; IDEXWriteReg = 5'd5; IFIDrs = 5'd5;
      @(posedge Clk);
      #1;
      do_reset("rst");
      clear_inputs();

      // load-use: lw $5 in EX, add reads $5
      IDEXMemRead = 1'b1; IDEXRegWrite = 1'b1; IDEXWriteReg = 5'd5; IFIDrs = 5'd5;
      step("lu");
      chk("lu.cnt1", {28'd0, StallCount}, 32'd1);
      IDEXMemRead = 1'b0; IDEXRegWrite = 1'b0; IDEXWriteReg = 5'd0;
      step("lu_bub");

      // beq on lw $3 in EX: RUN stall then HOLD stall, flush suppressed in HOLD
      clear_inputs();
      IFIDBranch = 1'b1; IFIDrs = 5'd3; IDEXMemRead = 1'b1; IDEXRegWrite = 1'b1; IDEXWriteReg = 5'd3;
      step("bl2_run");
      BranchTaken = 1'b1;
      step("bl2_hold");
      chk("bl2.cnt3", {28'd0, StallCount}, 32'd3);
      IDEXMemRead = 1'b0; IDEXRegWrite = 1'b0; IDEXWriteReg = 5'd0;
      step("bl2_rel");

      // beq on rt=7 with ALU write in EX; then same with write reg 0
      clear_inputs();
      IFIDBranch = 1'b1; IFIDrs = 5'd1; IFIDrt = 5'd7; IFIDUsesRt = 1'b1;
      IDEXRegWrite = 1'b1; IDEXWriteReg = 5'd7;
      step("ba");
      IDEXWriteReg = 5'd0; IFIDrt = 5'd0;
      step("ba_r0");

      // lw $4 in EX, ID has rt=4 as a target only
      clear_inputs();
      IDEXMemRead = 1'b1; IDEXRegWrite = 1'b1; IDEXWriteReg = 5'd4; IFIDrt = 5'd4; IFIDrs = 5'd9;
      step("no_rt");

      // beq on load in MEM
      clear_inputs();
      IFIDBranch = 1'b1; IFIDrs = 5'd6; EXMemMemRead = 1'b1; EXMemWriteReg = 5'd6;
      step("bl1");

      // reset in the middle of HOLD
      clear_inputs();
      IFIDBranch = 1'b1; IFIDrs = 5'd2; IDEXMemRead = 1'b1; IDEXWriteReg = 5'd2;
      step("pre_hold");
      do_reset("rst_hold");
      clear_inputs();
      step("post_rst");

      // saturation: continuous load-use for 2^CNT_W+3 cycles
      IDEXMemRead = 1'b1; IDEXWriteReg = 5'd8; IFIDrs = 5'd8;
      for (int i = 0; i < (1 << CNT_W) + 3; i++) step("sat");
      chk("sat.hold15", {28'd0, StallCount}, 32'd15);

      do_reset("rst2");
      // randomized traffic on a small register range so matches are frequent
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 60) == 0) begin
            clear_inputs();
            do_reset("rnd_rst");
         end
         IFIDrs        = 5'($urandom_range(0, 3));
         IFIDrt        = 5'($urandom_range(0, 3));
         IFIDUsesRt    = 1'($urandom);
         IFIDBranch    = 1'($urandom);
         IDEXWriteReg  = 5'($urandom_range(0, 3));
         IDEXRegWrite  = 1'($urandom);
         IDEXMemRead   = ($urandom_range(0, 2) == 0);
         EXMemWriteReg = 5'($urandom_range(0, 3));
         EXMemMemRead  = 1'($urandom);
         BranchTaken   = 1'($urandom);
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/bubble counterpart to the pipeline's operand forwarding logic. Forwarding covers RAW hazards it can bypass; this block stalls for the hazards it cannot.
- Sits beside the IF/ID register. It holds PC and IF/ID, injects a bubble into ID/EX, and flushes IF/ID on a taken branch.
- Small FSM tracks multi-cycle stalls; saturating counter reports total stall cycles for performance debug.

Parameters:
- CNT_W, 16, width of StallCount performance counter.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- IFIDrs  input  5  rs field of instruction in ID.
- IFIDrt  input  5  rt field of instruction in ID.
- IFIDUsesRt  input  1  ID instruction reads rt as a source (R-type, beq/bne, sw).
- IFIDBranch  input  1  ID instruction is beq/bne, compared in ID.
- IDEXWriteReg  input  5  destination register of instruction in EX (already rd/rt muxed).
- IDEXRegWrite  input  1  EX instruction writes a register.
- IDEXMemRead  input  1  EX instruction is a load.
- EXMemWriteReg  input  5  destination register of instruction in MEM.
- EXMemMemRead  input  1  MEM instruction is a load.
- BranchTaken  input  1  branch resolved taken in ID this cycle.
- PCWrite  output  1  1 = PC may update.
- IFIDWrite  output  1  1 = IF/ID may load.
- IDEXBubble  output  1  1 = zero ID/EX control signals.
- IFIDFlush  output  1  1 = clear IF/ID (squash fetched instruction).
- StallCount  output  CNT_W  number of stall cycles since reset.

Behaviour:
- Register 0 never causes a hazard. Every match below also requires the write register to be non-zero.
- Definition: src match(X) = (X==IFIDrs) || (IFIDUsesRt && X==IFIDrt).
- Hazard terms, evaluated combinationally:
  - H_LU (load-use, 1 cycle): IDEXMemRead && match(IDEXWriteReg).
  - H_BA (branch on ALU result in EX, 1 cycle): IFIDBranch && IDEXRegWrite && !IDEXMemRead && match(IDEXWriteReg).
  - H_BL2 (branch on load in EX, 2 cycles): IFIDBranch && IDEXMemRead && match(IDEXWriteReg).
  - H_BL1 (branch on load in MEM, 1 cycle): IFIDBranch && EXMemMemRead && match(EXMemWriteReg).
- FSM states: RUN, HOLD.
- In RUN, Stall = H_LU | H_BA | H_BL1 | H_BL2. Outputs are Mealy, asserted in the same cycle the hazard is seen.
  - H_BL2 -> next HOLD; H_BL2 has priority over the 1-cycle terms.
  - Any other hazard -> stay RUN; the hazard re-evaluates next cycle.
- HOLD: Stall = 1 unconditionally, inputs ignored, next state RUN. Exactly one HOLD cycle.
- Stall = 1 drives PCWrite=0, IFIDWrite=0, IDEXBubble=1.
- Stall = 0 drives PCWrite=1, IFIDWrite=1, IDEXBubble=0.
- IFIDFlush = BranchTaken && !Stall. A stall suppresses the flush because the branch is unresolved.
- StallCount increments by 1 on each rising Clk edge where Stall=1. It saturates at all-ones and does not wrap.
- Reset asserted:
  - State goes to RUN, StallCount=0.
  - Outputs forced to PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0, independent of other inputs.
- Reset asserted while in HOLD aborts the remaining stall immediately.
- Deassertion: first evaluation on the first edge after Reset falls.
- Simultaneous H_LU and H_BL2 in RUN: 2-cycle path (HOLD) is taken.
- BranchTaken during HOLD: IFIDFlush=0.

Test Plan:
- lw $5 in EX (IDEXMemRead=1, IDEXWriteReg=5), add using IFIDrs=5 in ID -> PCWrite=0, IFIDWrite=0, IDEXBubble=1 for 1 cycle; StallCount 0->1; next cycle with bubble in EX -> no stall.
- beq IFIDrs=3, lw $3 in EX -> stall 2 consecutive cycles (RUN then HOLD), StallCount=2, then RUN with outputs released; BranchTaken=1 during HOLD -> IFIDFlush=0, and in the following RUN cycle -> IFIDFlush=1.
- beq IFIDrt=7 with IFIDUsesRt=1, EX add writes $7 -> 1-cycle stall. Same with EX write reg 0 -> no stall.
- lw $4 in EX, ID instruction IFIDrt=4 with IFIDUsesRt=0 (addi target) -> no stall, PCWrite=1.
- Reset pulsed mid-HOLD -> outputs immediately PCWrite=1, IDEXBubble=0, StallCount=0; state RUN after release.
- Force Stall for 2^CNT_W+3 cycles (CNT_W=4 build) -> StallCount holds at 15, no wrap.
